// File: rtl/motor_pkg.sv
// Shared types and constants for the motor ramp sequencer.
// Holds the sequencer state enum, the command-status flag bundle,
// the speed ceiling and the direction encodings.
// Optional feature macro: MOTOR_ESTOP_EN (adds the ESTOP state).
package motor_pkg;

  localparam int unsigned MOTOR_MAX_SPEED = 100;
  localparam logic        DIR_FWD         = 1'b1;
  localparam logic        DIR_REV         = 1'b0;

  typedef enum logic [2:0] {
    S_HOLD,
    S_RAMP,
    S_BRAKE,
    S_DWELL
`ifdef MOTOR_ESTOP_EN
    , S_ESTOP
`endif
  } motor_state_t;

  // Registered status flags that follow the state register
  typedef struct packed {
    logic cmd_ready;
    logic busy;
    logic at_target;
  } motor_status_t;

  // Status flags implied by a state
  function automatic motor_status_t status_of(motor_state_t s);
    motor_status_t st;
    st.cmd_ready = (s == S_HOLD) || (s == S_RAMP) || (s == S_BRAKE);
    st.busy      = (s != S_HOLD);
    st.at_target = (s == S_HOLD);
    return st;
  endfunction

endpackage

// File: rtl/motor_ramp_ctrl_if.sv
// Command handshake bundle for motor_ramp_ctrl.
// Signals: cmd_valid (command presented), cmd_ready (command can be taken),
// cmd_speed (target speed 0..255), cmd_dir (1 = forward, 0 = reverse).
// master = command source, slave = sequencer.
interface motor_ramp_ctrl_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_speed;
  logic       cmd_dir;

  modport master (
    output cmd_valid,
    output cmd_speed,
    output cmd_dir,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_speed,
    input  cmd_dir,
    output cmd_ready
  );

endinterface

// File: rtl/ramp_tick_gen.sv
// Free-running ramp prescaler: one single-cycle tick every RAMP_DIV cycles.
// Ports: clk_10k (clock), rst_n (async active-low reset), tick (step strobe).
// The counter runs 0..RAMP_DIV-1 and tick is high while it holds RAMP_DIV-1.
module ramp_tick_gen #(
  parameter int unsigned RAMP_DIV = 100
) (
  input  logic clk_10k,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned    CW   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(RAMP_DIV - 1);
  localparam logic [CW-1:0]  PRE  = CW'(RAMP_DIV - 2);

  logic [CW-1:0] cnt;

  // tick is registered one count early so it coincides with cnt == LAST
  always_ff @(posedge clk_10k or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
      tick <= (RAMP_DIV == 1) ? 1'b1 : (cnt == PRE);
    end
  end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Motion sequencer in front of the PWM motor driver.
// Accepts speed/direction commands and ramps speed one step per prescaler
// tick; reversals go brake -> dead-time dwell -> ramp-up so direction only
// ever changes at zero speed.
// Ports: clk_10k, rst_n (async active-low), cmd (command handshake, slave),
//        estop (only with MOTOR_ESTOP_EN), speed[7:0], direction, busy,
//        at_target.
// Optional feature macro: MOTOR_ESTOP_EN (emergency stop input and state).
module motor_ramp_ctrl
  import motor_pkg::*;
#(
  parameter int unsigned RAMP_DIV  = 100,
  parameter int unsigned DWELL_CYC = 500,
  parameter int unsigned MAX_SPEED = MOTOR_MAX_SPEED
) (
  input  logic                clk_10k,
  input  logic                rst_n,
  motor_ramp_ctrl_if.slave    cmd,
`ifdef MOTOR_ESTOP_EN
  input  logic                estop,
`endif
  output logic [7:0]          speed,
  output logic                direction,
  output logic                busy,
  output logic                at_target
);

  localparam int unsigned    DWW        = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam logic [DWW-1:0] DWELL_LOAD = DWW'(DWELL_CYC - 1);
  localparam logic [7:0]     MAX_S      = 8'(MAX_SPEED);

  motor_state_t   state;
  motor_status_t  status_q;
  logic [7:0]     tgt_speed;
  logic           tgt_dir;
  logic [DWW-1:0] dwell_cnt;
  logic           tick;

  logic           accept;
  logic [7:0]     tgt_new;
  logic [7:0]     ramp_next;
  motor_state_t   acc_state;

  ramp_tick_gen #(.RAMP_DIV(RAMP_DIV)) u_tick (
    .clk_10k (clk_10k),
    .rst_n   (rst_n),
    .tick    (tick)
  );

  assign cmd.cmd_ready = status_q.cmd_ready;
  assign busy          = status_q.busy;
  assign at_target     = status_q.at_target;

  assign accept  = cmd.cmd_valid && status_q.cmd_ready;
  assign tgt_new = (cmd.cmd_speed > MAX_S) ? MAX_S : cmd.cmd_speed;

  // One step toward the target; never called with speed == tgt_speed
  assign ramp_next = (speed < tgt_speed) ? speed + 8'd1 : speed - 8'd1;

  // Destination state for a freshly accepted command
  always_comb begin
    acc_state = S_HOLD;
    if (cmd.cmd_dir == direction) begin
      acc_state = (speed == tgt_new) ? S_HOLD : S_RAMP;
    end else begin
      acc_state = (speed == 8'd0) ? S_DWELL : S_BRAKE;
    end
  end

  // Sequencer FSM with target registers, dwell counter and status flags
  always_ff @(posedge clk_10k or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HOLD;
      status_q  <= status_of(S_HOLD);
      speed     <= 8'd0;
      direction <= DIR_FWD;
      tgt_speed <= 8'd0;
      tgt_dir   <= DIR_FWD;
      dwell_cnt <= '0;
    end
`ifdef MOTOR_ESTOP_EN
    else if (estop) begin
      // Target direction follows the held direction so release lands in HOLD
      state     <= S_ESTOP;
      status_q  <= status_of(S_ESTOP);
      speed     <= 8'd0;
      tgt_speed <= 8'd0;
      tgt_dir   <= direction;
    end else if (state == S_ESTOP) begin
      state     <= S_HOLD;
      status_q  <= status_of(S_HOLD);
      speed     <= 8'd0;
    end
`endif
    else if (accept) begin
      // A command takes precedence over a same-cycle ramp tick
      tgt_speed <= tgt_new;
      tgt_dir   <= cmd.cmd_dir;
      state     <= acc_state;
      status_q  <= status_of(acc_state);
      if (acc_state == S_DWELL) begin
        dwell_cnt <= DWELL_LOAD;
      end
    end else begin
      case (state)
        S_RAMP: begin
          if (tick) begin
            speed <= ramp_next;
            if (ramp_next == tgt_speed) begin
              state    <= S_HOLD;
              status_q <= status_of(S_HOLD);
            end
          end
        end
        S_BRAKE: begin
          if (tick) begin
            if (speed != 8'd0) begin
              speed <= speed - 8'd1;
            end
            if (speed <= 8'd1) begin
              state     <= S_DWELL;
              status_q  <= status_of(S_DWELL);
              dwell_cnt <= DWELL_LOAD;
            end
          end
        end
        S_DWELL: begin
          if (dwell_cnt == '0) begin
            direction <= tgt_dir;
            if (tgt_speed == 8'd0) begin
              state    <= S_HOLD;
              status_q <= status_of(S_HOLD);
            end else begin
              state    <= S_RAMP;
              status_q <= status_of(S_RAMP);
            end
          end else begin
            dwell_cnt <= dwell_cnt - DWW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Self-checking bench for motor_ramp_ctrl (RAMP_DIV = 4, DWELL_CYC = 8).
// A behavioural model tracks speed/direction/target and the dwell window;
// a compare process checks every output on every falling edge, and directed
// scenarios pin timing with hand-derived literal expectations.
// Honours MOTOR_ESTOP_EN when defined.
module tb_motor_ramp_ctrl;

  localparam int RDIV  = 4;
  localparam int DWELL = 8;
  localparam int MAXS  = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef MOTOR_ESTOP_EN
  logic estop = 1'b0;
`endif
  logic [7:0] speed;
  logic       direction;
  logic       busy;
  logic       at_target;

  motor_ramp_ctrl_if cmd_if ();

  motor_ramp_ctrl #(.RAMP_DIV(RDIV), .DWELL_CYC(DWELL), .MAX_SPEED(MAXS)) dut (
    .clk_10k   (clk),
    .rst_n     (rst_n),
    .cmd       (cmd_if),
`ifdef MOTOR_ESTOP_EN
    .estop     (estop),
`endif
    .speed     (speed),
    .direction (direction),
    .busy      (busy),
    .at_target (at_target)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_speed, m_dir, m_tgt, m_tdir;
  int m_dwelling, m_dwell_left, m_estop, m_edge;

  task automatic m_reset();
    m_speed = 0; m_dir = 1; m_tgt = 0; m_tdir = 1;
    m_dwelling = 0; m_dwell_left = 0; m_estop = 0; m_edge = 0;
  endtask

  function automatic int m_busy();
    return (m_estop != 0 || m_dwelling != 0 || m_speed != m_tgt || m_dir != m_tdir) ? 1 : 0;
  endfunction

  function automatic int m_ready();
    return (m_estop == 0 && m_dwelling == 0) ? 1 : 0;
  endfunction

  // One clock edge of the rules: estop, then dwell countdown, then command,
  // then the periodic step (every RDIV-th edge after reset).
  task automatic m_step();
    int tick;
    int cs;
    int est = 0;
`ifdef MOTOR_ESTOP_EN
    est = int'(estop);
`endif
    m_edge++;
    tick = (m_edge % RDIV == 0) ? 1 : 0;
    if (est != 0) begin
      m_speed = 0; m_tgt = 0; m_tdir = m_dir; m_estop = 1; m_dwelling = 0;
    end else if (m_estop != 0) begin
      m_estop = 0;
    end else if (m_dwelling != 0) begin
      if (m_dwell_left == 0) begin
        m_dir = m_tdir;
        m_dwelling = 0;
      end else begin
        m_dwell_left--;
      end
    end else if (cmd_if.cmd_valid === 1'b1) begin
      cs = int'(cmd_if.cmd_speed);
      m_tgt  = (cs > MAXS) ? MAXS : cs;
      m_tdir = int'(cmd_if.cmd_dir);
      if (m_tdir != m_dir && m_speed == 0) begin
        m_dwelling = 1; m_dwell_left = DWELL - 1;
      end
    end else if (tick != 0) begin
      if (m_dir != m_tdir) begin
        if (m_speed > 0) m_speed--;
        if (m_speed == 0) begin
          m_dwelling = 1; m_dwell_left = DWELL - 1;
        end
      end else if (m_speed < m_tgt) begin
        m_speed++;
      end else if (m_speed > m_tgt) begin
        m_speed--;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // ---------------- continuous compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("speed",     int'(speed),            m_speed);
      chk("direction", int'(direction),        m_dir);
      chk("cmd_ready", int'(cmd_if.cmd_ready), m_ready());
      chk("busy",      int'(busy),             m_busy());
      chk("at_target", int'(at_target),        1 - m_busy());
    end
  end

  // ---------------- stimulus helpers ----------------
  // Present a command now (caller is at a falling edge); acc = accept edge index
  task automatic send(input int sp, input int d, output int acc);
    cmd_if.cmd_speed = 8'(sp);
    cmd_if.cmd_dir   = d[0];
    cmd_if.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = m_edge;
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_speed(input string name, input int tgt, input int budget, output int hit);
    int n = 0;
    @(negedge clk);
    while (int'(speed) != tgt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_reached"}, (int'(speed) == tgt) ? 1 : 0, 1);
    hit = m_edge;
  endtask

  task automatic wait_idle(input string name, input int budget,
                           output int mx, output int mn, output int dchg);
    int n = 0;
    int d0;
    @(negedge clk);
    d0 = int'(direction);
    mx = int'(speed); mn = int'(speed); dchg = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
      if (int'(speed) > mx) mx = int'(speed);
      if (int'(speed) < mn) mn = int'(speed);
      if (int'(direction) != d0) dchg = 1;
    end
    chk({name, "_settled"}, (busy === 1'b0) ? 1 : 0, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_speed"},     int'(speed),            0);
    chk({tag, "_direction"}, int'(direction),        1);
    chk({tag, "_at_target"}, int'(at_target),        1);
    chk({tag, "_cmd_ready"}, int'(cmd_if.cmd_ready), 1);
    chk({tag, "_busy"},      int'(busy),             0);
  endtask

  task automatic random_cmds(input int count);
    int gap, sp, d, acc;
    for (int i = 0; i < count; i++) begin
      @(negedge clk);
`ifdef MOTOR_ESTOP_EN
      if ($urandom_range(0, 9) == 0) begin
        estop = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        estop = 1'b0;
      end
`endif
      sp  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(101, 255)) : int'($urandom_range(0, 100));
      d   = int'($urandom_range(0, 1));
      send(sp, d, acc);
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(300, 600)) : int'($urandom_range(1, 60));
      repeat (gap) @(negedge clk);
    end
  endtask

  // ---------------- directed scenarios + random ----------------
  initial begin
    int acc, hit, mx, mn, dchg, cnt, bad;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_speed = 8'd0;
    cmd_if.cmd_dir   = 1'b1;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_vals("reset");

    // 0 -> 50 forward: 50 ticks of 4 cycles
    send(50, 1, acc);
    wait_speed("ramp50", 50, 260, hit);
    chk_range("ramp50_cycles", hit - acc, 196, 204);
    chk("ramp50_busy_at_hit", int'(busy), 0);
    chk("ramp50_at_target", int'(at_target), 1);

    // 200 is clamped to 100
    @(negedge clk);
    send(200, 1, acc);
    wait_idle("clamp", 300, mx, mn, dchg);
    chk("clamp_max", mx, 100);
    chk("clamp_final", int'(speed), 100);

    // down to 10 forward
    @(negedge clk);
    send(10, 1, acc);
    wait_idle("down10", 420, mx, mn, dchg);
    chk("down10_final", int'(speed), 10);

    // reversal: brake 10 ticks, 8-cycle dwell, ramp to 20 reverse
    @(negedge clk);
    send(20, 0, acc);
    wait_speed("brake", 0, 60, hit);
    chk_range("brake_cycles", hit - acc, 36, 44);
    cnt = 0; bad = 0;
    while (cmd_if.cmd_ready === 1'b0 && cnt < 20) begin
      if (direction !== 1'b1) bad++;
      cnt++;
      @(negedge clk);
    end
    chk("dwell_len", cnt, DWELL);
    chk("dwell_dir_held", bad, 0);
    chk("rev_dir_after_dwell", int'(direction), 0);
    wait_idle("rev_ramp", 120, mx, mn, dchg);
    chk("rev_final_speed", int'(speed), 20);
    chk("rev_final_dir", int'(direction), 0);

    // back to forward at zero, then up to 12
    @(negedge clk);
    send(0, 1, acc);
    wait_idle("to_fwd0", 150, mx, mn, dchg);
    chk("to_fwd0_dir", int'(direction), 1);
    @(negedge clk);
    send(12, 1, acc);
    wait_idle("up12", 80, mx, mn, dchg);

    // brake cancelled at speed 5
    @(negedge clk);
    send(30, 0, acc);
    wait_speed("brake_to5", 5, 60, hit);
    send(30, 1, acc);
    wait_idle("cancel", 150, mx, mn, dchg);
    chk("cancel_min_speed", mn, 5);
    chk("cancel_dir_changes", dchg, 0);
    chk("cancel_final_speed", int'(speed), 30);
    chk("cancel_final_dir", int'(direction), 1);

`ifdef MOTOR_ESTOP_EN
    @(negedge clk);
    send(60, 1, acc);
    wait_idle("to60", 200, mx, mn, dchg);
    @(negedge clk);
    estop = 1'b1;
    cmd_if.cmd_speed = 8'd90;
    cmd_if.cmd_dir   = 1'b0;
    cmd_if.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    chk("estop_speed", int'(speed), 0);
    chk("estop_ready", int'(cmd_if.cmd_ready), 0);
    chk("estop_busy", int'(busy), 1);
    repeat (2) @(negedge clk);
    estop = 1'b0;
    @(posedge clk);
    #1;
    chk("estop_rel_busy", int'(busy), 0);
    chk("estop_rel_at_target", int'(at_target), 1);
    chk("estop_rel_speed", int'(speed), 0);
    chk("estop_rel_dir", int'(direction), 1);
`endif

    random_cmds(40);

    // asynchronous reset mid-ramp
    @(negedge clk);
    send(90, int'(~direction), acc);
    repeat (30) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;

    random_cmds(6);
    wait_idle("final", 1500, mx, mn, dchg);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
